memory_access: RTL
==================

# memory_access

- Pipeline stage between execute and write-back.
- Issues load/store transactions to the data-memory bus with a request/acknowledge handshake, holds the upstream pipeline while a transaction is outstanding, and aligns plus sign-/zero-extends load data.
- Registers the write-back-stage inputs: `write_back_type`, `pc`, `memory_read_output`, `execute_result`, `write_back_register_output`.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `write_back_type_input`  in  2  `WB_*` code from execute
- `pc_input`  in  32  instruction PC
- `execute_result_input`  in  32  ALU result; byte address for loads/stores
- `store_data`  in  32  rs2 value for stores
- `write_back_register_input`  in  5  destination register
- `memory_read`  in  1  instruction is a load
- `memory_write`  in  1  instruction is a store
- `memory_funct3`  in  3  `MEM_B`=000, `MEM_H`=001, `MEM_W`=010, `MEM_BU`=100, `MEM_HU`=101
- `stall`  out  1  combinational; upstream holds all inputs while high
- `dmem_req`  out  1  bus request
- `dmem_we`  out  1  write enable
- `dmem_addr`  out  32  word-aligned address, bits [1:0]=0
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_wstrb`  out  4  byte enables
- `dmem_ack`  in  1  transaction complete this cycle; may arrive in the same cycle as `dmem_req`
- `dmem_rdata`  in  32  read word, valid when `dmem_ack`=1
- `write_back_type`  out  2  registered
- `pc`  out  32  registered
- `execute_result`  out  32  registered
- `memory_read_output`  out  32  registered, extended load value
- `write_back_register_output`  out  5  registered
- `misaligned_fault`  out  1  registered one-cycle pulse

## Operation
- Memory op = `memory_read | memory_write`. If both are set, the write wins: store performed, `memory_read_output`=0.
- Non-memory op:
  - One-cycle pass-through.
  - `stall`=0, `dmem_req`=0.
- FSM states: `S_FIRST`, `S_SECOND`. Reset state is `S_FIRST`.
- `S_FIRST` with memory op:
  - `dmem_req`=1, `dmem_addr` = addr & ~3, `dmem_we` = `memory_write`.
  - Byte offset `o` = addr[1:0].
  - Store strobes: B → 0001<<o; H → 0011<<o; W → 1111<<o. Take the low 4 bits of each shifted strobe.
  - Store data: `dmem_wdata` = `store_data`<<(8*o).
- Load extraction: word = `dmem_rdata`>>(8*o). B/H sign-extend bit 7/15; BU/HU zero-extend; W as-is.
- Access spans two words when (H and o=3) or (W and o≠0):
  - With `MISALIGNED_SPLIT_EN`: on ack in `S_FIRST`, capture the low part of the result and go to `S_SECOND`. `S_SECOND` requests (addr & ~3)+4 with strobes/data for the remaining bytes. On ack, merge the parts, then extend.
  - Without it: see Configuration.
- `stall` = memory op & ~(final ack this cycle).
- Output register update at each edge:
  - Final ack, or non-memory op: capture inputs and load result.
  - Stall cycle: load `write_back_type`=`WB_HICCUP`, `write_back_register_output`=0 (bubble).
- Reset values: `write_back_type`=`WB_HICCUP`; all other outputs 0; `misaligned_fault`=0. During `rst`, `dmem_req`=0 and `stall`=0.

## Timing
- Zero-wait memory (ack in the request cycle): latency 1, identical to non-memory ops, no stall.
- N wait cycles: N stall cycles and N bubbles. Result appears on the edge ending the ack cycle.
- Split access: at least 2 cycles; `stall` stays high through the first ack.
- `dmem_req`, `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` stay stable from request until ack.
- Reset during wait: FSM returns to `S_FIRST` and the transaction is abandoned. The memory model shares `rst` and drops pending requests.
- Back-to-back memory ops: a new request may be issued in the cycle after the final ack.

## Configuration
- Macro: `MISALIGNED_SPLIT_EN`.
- Defined: spanning accesses split into two aligned transactions as above; `misaligned_fault` tied 0.
- Undefined:
  - A spanning access issues no request and no stall.
  - Output `write_back_type`=`WB_HICCUP`, `write_back_register_output`=0.
  - `misaligned_fault` pulses 1 for one cycle.
  - `S_SECOND` is not built.

## Structure
- `src/format.vh` gains:
  - `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`
  - `S_FIRST`, `S_SECOND`
- Existing `WB_*` codes from `src/format.vh` are reused.
- Sub-module `load_align`: combinational shift plus sign/zero extension of the load word (offset, funct3). Also used for the merged split result.

## Test plan
- ALU op, `WB_NORMAL`, result 0x1234, rd=5, no memory → next edge: `execute_result`=0x1234, rd=5, `stall`=0.
- LB at 0x103, `dmem_rdata`=0x80FFFFFF, ack same cycle → `memory_read_output`=0xFFFFFF80; LBU → 0x00000080.
- SH at 0x102, `store_data`=0xABCD → `dmem_addr`=0x100, `dmem_wstrb`=1100, `dmem_wdata`=0xABCD0000.
- LW with ack delayed 3 cycles → `stall` high 3 cycles, 3 `WB_HICCUP` bubbles, then data.
- LW at 0x101, words 0x44332211 and 0x88776655:
  - Split defined: 2 requests (0x100, 0x104), result 0x55443322.
  - Split undefined: `misaligned_fault`=1, `WB_HICCUP`, no request.
- `rst` asserted during a wait → next cycle `dmem_req`=0, `write_back_type`=`WB_HICCUP`, FSM in `S_FIRST`.

Source files
------------

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared codes for the memory-access pipeline stage.
// Write-back selector codes, load/store size codes, FSM states and small
// helpers for classifying an access by size and byte offset.
package memory_access_pkg;

  localparam logic [1:0] WB_NORMAL = 2'b00;
  localparam logic [1:0] WB_MEMORY = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] WB_HICCUP = 2'b11;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  // An access crosses a word boundary when a halfword starts in the last
  // byte lane or a word starts anywhere but lane 0.
  function automatic logic spans_two_words(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    return ((funct3[1:0] == 2'b01) && (offset == 2'b11)) ||
           ((funct3[1:0] == 2'b10) && (offset != 2'b00));
  endfunction

  // Byte-enable pattern for an access of the given size at lane 0.
  function automatic logic [3:0] size_strobe(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: request/acknowledge data-memory bus.
// The stage drives the request side (master); the memory answers (slave).
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/memory_access_load_align.sv
// load_align: moves the addressed byte lane of a read word down to bit 0
// and sign- or zero-extends it according to the load size.
module load_align
  import memory_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [31:0] shifted;

  // Shift the selected lane down, then extend from bit 7/15 or leave as-is
  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      MEM_B:   value = {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   value = {{16{shifted[15]}}, shifted[15:0]};
      MEM_BU:  value = {24'b0, shifted[7:0]};
      MEM_HU:  value = {16'b0, shifted[15:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline stage between execute and write-back.
// Issues loads/stores on the dmem bus, stalls upstream while a transaction
// is outstanding, aligns/extends load data and registers write-back inputs.
// Optional feature macro: MISALIGNED_SPLIT_EN (split word-crossing accesses
// into two aligned transactions; otherwise they raise misaligned_fault).
module memory_access
  import memory_access_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             write_back_type_input,
  input  logic [31:0]            pc_input,
  input  logic [31:0]            execute_result_input,
  input  logic [31:0]            store_data,
  input  logic [4:0]             write_back_register_input,
  input  logic                   memory_read,
  input  logic                   memory_write,
  input  logic [2:0]             memory_funct3,
  output logic                   stall,
  memory_access_if.master        dmem,
  output logic [1:0]             write_back_type,
  output logic [31:0]            pc,
  output logic [31:0]            execute_result,
  output logic [31:0]            memory_read_output,
  output logic [4:0]             write_back_register_output,
  output logic                   misaligned_fault
);

  logic        mem_op;
  logic        spanning;
  logic        final_ack;
  logic        fault_now;
  logic [1:0]  offset;
  logic [31:0] word_addr;
  logic [31:0] align_word;
  logic [1:0]  align_offset;
  logic [31:0] load_value;

  logic [1:0]  write_back_type_d, write_back_type_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] execute_result_d, execute_result_q;
  logic [31:0] memory_read_output_d, memory_read_output_q;
  logic [4:0]  write_back_register_d, write_back_register_q;
  logic        misaligned_fault_d, misaligned_fault_q;

  assign mem_op    = memory_read | memory_write;
  assign offset    = execute_result_input[1:0];
  assign word_addr = {execute_result_input[31:2], 2'b00};
  assign spanning  = mem_op && spans_two_words(memory_funct3, offset);

`ifdef MISALIGNED_SPLIT_EN
  state_e      state_d, state_q;
  logic [31:0] first_word_d, first_word_q;
  logic [63:0] wdata_wide;
  logic [7:0]  wstrb_wide;
  logic [63:0] joined;

  assign wdata_wide = {32'b0, store_data} << {offset, 3'b000};
  assign wstrb_wide = {4'b0, size_strobe(memory_funct3)} << offset;

  // Drive the bus and sequence the first/second half of a crossing access
  always_comb begin
    state_d      = state_q;
    first_word_d = first_word_q;
    dmem.req     = 1'b0;
    dmem.we      = 1'b0;
    dmem.addr    = 32'b0;
    dmem.wdata   = 32'b0;
    dmem.wstrb   = 4'b0;
    final_ack    = 1'b0;
    fault_now    = 1'b0;
    joined       = {dmem.rdata, first_word_q} >> {offset, 3'b000};
    align_word   = dmem.rdata;
    align_offset = offset;
    if (!rst && mem_op) begin
      dmem.req = 1'b1;
      dmem.we  = memory_write;
      if (state_q == S_SECOND) begin
        dmem.addr    = word_addr + 32'd4;
        dmem.wdata   = wdata_wide[63:32];
        dmem.wstrb   = memory_write ? wstrb_wide[7:4] : 4'b0;
        align_word   = joined[31:0];
        align_offset = 2'b00;
        if (dmem.ack) begin
          final_ack = 1'b1;
          state_d   = S_FIRST;
        end
      end else begin
        dmem.addr  = word_addr;
        dmem.wdata = wdata_wide[31:0];
        dmem.wstrb = memory_write ? wstrb_wide[3:0] : 4'b0;
        if (dmem.ack) begin
          if (spanning) begin
            first_word_d = dmem.rdata;
            state_d      = S_SECOND;
          end else begin
            final_ack = 1'b1;
          end
        end
      end
    end
  end

  // Split-access state and the captured low word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FIRST;
      first_word_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      first_word_q <= first_word_d;
    end
  end
`else
  // Drive the bus for aligned accesses; crossing accesses only raise a fault
  always_comb begin
    dmem.req     = 1'b0;
    dmem.we      = 1'b0;
    dmem.addr    = 32'b0;
    dmem.wdata   = 32'b0;
    dmem.wstrb   = 4'b0;
    final_ack    = 1'b0;
    fault_now    = !rst && spanning;
    align_word   = dmem.rdata;
    align_offset = offset;
    if (!rst && mem_op && !spanning) begin
      dmem.req   = 1'b1;
      dmem.we    = memory_write;
      dmem.addr  = word_addr;
      dmem.wdata = store_data << {offset, 3'b000};
      dmem.wstrb = memory_write ? (size_strobe(memory_funct3) << offset) : 4'b0;
      final_ack  = dmem.ack;
    end
  end
`endif

  assign stall = !rst && mem_op && !final_ack && !fault_now;

  load_align u_load_align (
    .word   (align_word),
    .offset (align_offset),
    .funct3 (memory_funct3),
    .value  (load_value)
  );

  // Choose what the write-back registers take: result, bubble or fault
  always_comb begin
    write_back_type_d     = write_back_type_q;
    pc_d                  = pc_q;
    execute_result_d      = execute_result_q;
    memory_read_output_d  = memory_read_output_q;
    write_back_register_d = write_back_register_q;
    misaligned_fault_d    = 1'b0;
    if (final_ack || !mem_op) begin
      write_back_type_d     = write_back_type_input;
      pc_d                  = pc_input;
      execute_result_d      = execute_result_input;
      write_back_register_d = write_back_register_input;
      memory_read_output_d  = (memory_read && !memory_write) ? load_value : 32'b0;
    end else if (fault_now) begin
      write_back_type_d     = WB_HICCUP;
      write_back_register_d = 5'b0;
      pc_d                  = pc_input;
      execute_result_d      = execute_result_input;
      memory_read_output_d  = 32'b0;
      misaligned_fault_d    = 1'b1;
    end else begin
      write_back_type_d     = WB_HICCUP;
      write_back_register_d = 5'b0;
    end
  end

  // Write-back stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      write_back_type_q     <= WB_HICCUP;
      pc_q                  <= 32'b0;
      execute_result_q      <= 32'b0;
      memory_read_output_q  <= 32'b0;
      write_back_register_q <= 5'b0;
      misaligned_fault_q    <= 1'b0;
    end else begin
      write_back_type_q     <= write_back_type_d;
      pc_q                  <= pc_d;
      execute_result_q      <= execute_result_d;
      memory_read_output_q  <= memory_read_output_d;
      write_back_register_q <= write_back_register_d;
      misaligned_fault_q    <= misaligned_fault_d;
    end
  end

  assign write_back_type            = write_back_type_q;
  assign pc                         = pc_q;
  assign execute_result             = execute_result_q;
  assign memory_read_output         = memory_read_output_q;
  assign write_back_register_output = write_back_register_q;
  assign misaligned_fault           = misaligned_fault_q;

endmodule
